ballot_controller: RTL and testbench

Sequencing front-end for the three-candidate vote counters. A poll officer issues one ballot at a time; the block accepts exactly one valid button press per ballot and converts it into a single-cycle increment pulse for the matching candidate counter. It rejects multi-presses, expires unused ballots, and enforces a post-vote lockout. Once voting is over it latches a closed state that drives the counters' result-enable.

---
 rtl/ballot_controller.sv | 135 +++++++++++++
 tb/tb_ballot_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ballot_controller.sv
// Ballot sequencer: arms one ballot, accepts one clean button press, pulses the
// matching counter increment, spoils expired/aborted ballots, latches closed state.
module ballot_controller #(
  parameter int          LOCKOUT_CYCLES = 16,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] COUNT_INIT     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ballot,
  input  logic        i_candidate_1,
  input  logic        i_candidate_2,
  input  logic        i_candidate_3,
  input  logic        i_over,
  output logic        o_inc_1,
  output logic        o_inc_2,
  output logic        o_inc_3,
  output logic        o_ready,
  output logic        o_invalid,
  output logic        o_timeout,
  output logic        o_closed,
  output logic [15:0] o_ballots,
  output logic [15:0] o_spoiled
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WAIT_RELEASE,
    LOCKOUT,
    CLOSED
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [LW-1:0] lock_cnt;
  logic          prev_ballot;
  logic [2:0]    prev_cand;
  logic [2:0]    pressed;
  logic [2:0]    cand_edge;
  logic          ballot_edge;
  logic          one_pressed;
  logic          vote_valid;
  logic          vote_multi;

  assign pressed     = {i_candidate_3, i_candidate_2, i_candidate_1};
  assign cand_edge   = pressed & ~prev_cand;
  assign ballot_edge = i_ballot & ~prev_ballot;
  assign one_pressed = (pressed != 3'd0) && ((pressed & (pressed - 3'd1)) == 3'd0);
  // An edge implies its button is pressed, so "not one-hot" means two or more held.
  assign vote_valid  = (cand_edge != 3'd0) && one_pressed;
  assign vote_multi  = (cand_edge != 3'd0) && !one_pressed;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      lock_cnt    <= '0;
      prev_ballot <= 1'b0;
      prev_cand   <= 3'd0;
      o_inc_1     <= 1'b0;
      o_inc_2     <= 1'b0;
      o_inc_3     <= 1'b0;
      o_ready     <= 1'b0;
      o_invalid   <= 1'b0;
      o_timeout   <= 1'b0;
      o_closed    <= 1'b0;
      o_ballots   <= COUNT_INIT;
      o_spoiled   <= COUNT_INIT;
    end else begin
      prev_ballot <= i_ballot;
      prev_cand   <= pressed;
      o_inc_1     <= 1'b0;
      o_inc_2     <= 1'b0;
      o_inc_3     <= 1'b0;
      o_invalid   <= 1'b0;
      o_timeout   <= 1'b0;
      if (i_over) begin
        if (state == ARMED) o_spoiled <= sat_inc(o_spoiled);
        state    <= CLOSED;
        o_ready  <= 1'b0;
        o_closed <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (ballot_edge) begin
              state     <= ARMED;
              o_ready   <= 1'b1;
              o_ballots <= sat_inc(o_ballots);
              timer     <= '0;
            end
          end
          ARMED: begin
            timer <= timer + TW'(1);
            if (vote_valid) begin
              o_inc_1 <= pressed[0];
              o_inc_2 <= pressed[1];
              o_inc_3 <= pressed[2];
              o_ready <= 1'b0;
              state   <= WAIT_RELEASE;
            end else if (vote_multi) begin
              o_invalid <= 1'b1;
            // >= so an invalid press in the last cycle only defers expiry by one.
            end else if (timer >= TW'(TIMEOUT_CYCLES - 1)) begin
              o_timeout <= 1'b1;
              o_spoiled <= sat_inc(o_spoiled);
              o_ready   <= 1'b0;
              state     <= IDLE;
            end
          end
          WAIT_RELEASE: begin
            if (pressed == 3'd0) begin
              state    <= LOCKOUT;
              lock_cnt <= '0;
            end
          end
          LOCKOUT: begin
            if (lock_cnt == LW'(LOCKOUT_CYCLES - 1)) state <= IDLE;
            else lock_cnt <= lock_cnt + LW'(1);
          end
          CLOSED: state <= CLOSED;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller with short timeout/lockout and a
// second instance whose counters start near saturation.
module tb_ballot_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_ballot = 1'b0;
  logic i_candidate_1 = 1'b0;
  logic i_candidate_2 = 1'b0;
  logic i_candidate_3 = 1'b0;
  logic i_over = 1'b0;

  logic        o_inc_1, o_inc_2, o_inc_3, o_ready, o_invalid, o_timeout, o_closed;
  logic [15:0] o_ballots, o_spoiled;
  logic        s_inc_1, s_inc_2, s_inc_3, s_ready, s_invalid, s_timeout, s_closed;
  logic [15:0] s_ballots, s_spoiled;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ballot_controller #(.LOCKOUT_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .i_ballot(i_ballot),
    .i_candidate_1(i_candidate_1), .i_candidate_2(i_candidate_2),
    .i_candidate_3(i_candidate_3), .i_over(i_over),
    .o_inc_1(o_inc_1), .o_inc_2(o_inc_2), .o_inc_3(o_inc_3),
    .o_ready(o_ready), .o_invalid(o_invalid), .o_timeout(o_timeout),
    .o_closed(o_closed), .o_ballots(o_ballots), .o_spoiled(o_spoiled)
  );

  ballot_controller #(.LOCKOUT_CYCLES(4), .TIMEOUT_CYCLES(8), .COUNT_INIT(16'hFFFD)) dut_sat (
    .clk(clk), .rst(rst), .i_ballot(i_ballot),
    .i_candidate_1(i_candidate_1), .i_candidate_2(i_candidate_2),
    .i_candidate_3(i_candidate_3), .i_over(i_over),
    .o_inc_1(s_inc_1), .o_inc_2(s_inc_2), .o_inc_3(s_inc_3),
    .o_ready(s_ready), .o_invalid(s_invalid), .o_timeout(s_timeout),
    .o_closed(s_closed), .o_ballots(s_ballots), .o_spoiled(s_spoiled)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset values
    step();
    check("rst_ready",   32'(o_ready),   32'd0);
    check("rst_closed",  32'(o_closed),  32'd0);
    check("rst_inc",     32'({o_inc_3, o_inc_2, o_inc_1}), 32'd0);
    check("rst_pulses",  32'({o_invalid, o_timeout}), 32'd0);
    check("rst_ballots", 32'(o_ballots), 32'd0);
    check("rst_spoiled", 32'(o_spoiled), 32'd0);
    rst = 1'b0;
    step();

    // Ballot then candidate 2
    i_ballot = 1'b1; step(); i_ballot = 1'b0;
    check("arm_ready",   32'(o_ready),   32'd1);
    check("arm_ballots", 32'(o_ballots), 32'd1);
    i_candidate_2 = 1'b1; step();
    check("c2_inc", 32'({o_inc_3, o_inc_2, o_inc_1}), 32'b010);
    check("c2_ready_drop", 32'(o_ready), 32'd0);
    i_candidate_2 = 1'b0; step();
    check("c2_one_cycle", 32'({o_inc_3, o_inc_2, o_inc_1}), 32'd0);

    // Lockout: release sampled above; ballot edges at +2 (ignored) and +5 (accepted)
    step();
    i_ballot = 1'b1; step(); i_ballot = 1'b0;
    check("lock_ignored", 32'(o_ready), 32'd0);
    steps(2);
    i_ballot = 1'b1; step(); i_ballot = 1'b0;
    check("lock_accept_ready", 32'(o_ready),   32'd1);
    check("lock_ballots",      32'(o_ballots), 32'd2);

    // Multi-press then clean press of candidate 3
    i_candidate_1 = 1'b1; i_candidate_3 = 1'b1; step();
    check("multi_invalid", 32'(o_invalid), 32'd1);
    check("multi_no_inc",  32'({o_inc_3, o_inc_2, o_inc_1}), 32'd0);
    check("multi_ready",   32'(o_ready), 32'd1);
    step();
    check("multi_pulse_once", 32'(o_invalid), 32'd0);
    i_candidate_1 = 1'b0; i_candidate_3 = 1'b0; step();
    i_candidate_3 = 1'b1; step();
    check("c3_inc", 32'({o_inc_3, o_inc_2, o_inc_1}), 32'b100);
    i_candidate_3 = 1'b0; step();
    steps(5);

    // Expiry with no press
    i_ballot = 1'b1; step(); i_ballot = 1'b0;
    check("to_arm", 32'(o_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      step();
      check("to_early", 32'(o_timeout), 32'd0);
    end
    step();
    check("to_pulse",   32'(o_timeout), 32'd1);
    check("to_ready",   32'(o_ready),   32'd0);
    check("to_spoiled", 32'(o_spoiled), 32'd1);
    step();
    check("to_one_cycle", 32'(o_timeout), 32'd0);

    // Vote in the terminal timer cycle counts
    i_ballot = 1'b1; step(); i_ballot = 1'b0;
    steps(7);
    i_candidate_1 = 1'b1; step();
    check("last_inc",  32'({o_inc_3, o_inc_2, o_inc_1}), 32'b001);
    check("last_no_to", 32'(o_timeout), 32'd0);
    step();
    check("last_no_to_after", 32'(o_timeout), 32'd0);
    check("last_spoiled",     32'(o_spoiled), 32'd1);
    i_candidate_1 = 1'b0; step();
    steps(5);

    // Button held at arming does not vote; then close while armed
    i_candidate_2 = 1'b1; step();
    i_ballot = 1'b1; step(); i_ballot = 1'b0;
    check("held_arm_ballots", 32'(o_ballots), 32'd5);
    step();
    check("held_no_inc", 32'({o_inc_3, o_inc_2, o_inc_1}), 32'd0);
    i_over = 1'b1; step(); i_over = 1'b0; i_candidate_2 = 1'b0;
    check("over_closed",  32'(o_closed),  32'd1);
    check("over_ready",   32'(o_ready),   32'd0);
    check("over_spoiled", 32'(o_spoiled), 32'd2);
    i_candidate_1 = 1'b1; i_ballot = 1'b1; step();
    check("closed_no_inc",  32'({o_inc_3, o_inc_2, o_inc_1}), 32'd0);
    check("closed_ballots", 32'(o_ballots), 32'd5);
    i_candidate_1 = 1'b0; i_ballot = 1'b0;
    steps(10);
    check("closed_quiet", 32'({o_timeout, o_invalid, o_ready}), 32'd0);
    check("closed_sticky", 32'(o_closed), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2_closed",  32'(o_closed),  32'd0);
    check("rst2_ballots", 32'(o_ballots), 32'd0);
    check("rst2_spoiled", 32'(o_spoiled), 32'd0);
    check("sat_init",     32'(s_ballots), 32'hFFFD);

    // Saturation: three expiring ballots on the preloaded instance
    for (int b = 0; b < 3; b++) begin
      i_ballot = 1'b1; step(); i_ballot = 1'b0;
      check("sat_ready", 32'(s_ready), 32'd1);
      if (b == 0) check("sat_b1", 32'(s_ballots), 32'hFFFE);
      steps(8);
      check("sat_to", 32'(s_timeout), 32'd1);
    end
    check("sat_ballots",    32'(s_ballots), 32'hFFFF);
    check("sat_spoiled",    32'(s_spoiled), 32'hFFFF);
    check("nosat_ballots",  32'(o_ballots), 32'd3);
    check("nosat_spoiled",  32'(o_spoiled), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
